bpb_write_scheduler: RTL

Owns the single write port of the branch prediction buffer (BPB). Two requesters share it:
- the fetch-side allocation path, which installs a new tag on a BPB miss;
- the execute-side resolution path, which updates a 2-bit saturating counter.
Resolution updates are buffered in a small in-order queue. Allocation victims come from a round-robin pointer. Updates aimed at an entry being reallocated are discarded.

---
 rtl/bpb_pkg.sv | 24 ++
 rtl/bpb_write_scheduler_if.sv | 37 +++
 rtl/bpb_write_scheduler_upd_fifo.sv | 83 ++++++++
 rtl/bpb_write_scheduler.sv | 111 +++++++++++
 4 files changed

// File: rtl/bpb_pkg.sv
// Shared types, counter constants and the saturating-counter helper for the
// branch prediction buffer write path.
package bpb_pkg;

    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_WEAK_NT = 2'b01;
    localparam cnt_t CNT_MAX     = 2'b11;
    localparam cnt_t CNT_MIN     = 2'b00;

    // Two-bit saturating increment on taken, decrement on not-taken.
    function automatic cnt_t cnt_sat_update(input cnt_t cnt, input logic taken);
        cnt_t res;
        if (taken) begin
            if (cnt == CNT_MAX) res = CNT_MAX;
            else                res = cnt + 2'b01;
        end else begin
            if (cnt == CNT_MIN) res = CNT_MIN;
            else                res = cnt - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/bpb_write_scheduler_if.sv
// Requester and BPB-port signals of the write scheduler. The slave side is the
// scheduler; the master side is the fetch/execute requesters plus the BPB array.
interface bpb_write_scheduler_if #(
    parameter int IDX_W     = 4,
    parameter int TAG_WIDTH = 30
);
    import bpb_pkg::*;

    logic                 alloc_req;
    logic [TAG_WIDTH-1:0] alloc_tag;
    logic                 alloc_ready;
    logic                 upd_valid;
    logic [IDX_W-1:0]     upd_idx;
    logic                 upd_taken;
    logic                 upd_ready;
    logic [IDX_W-1:0]     cnt_rd_idx;
    cnt_t                 cnt_rd_data;
    logic                 w_en;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_tag_en;
    logic [TAG_WIDTH-1:0] w_tag;
    logic                 w_valid;
    cnt_t                 w_cnt;

    modport master (
        output alloc_req, alloc_tag, upd_valid, upd_idx, upd_taken, cnt_rd_data,
        input  alloc_ready, upd_ready, cnt_rd_idx,
        input  w_en, w_idx, w_tag_en, w_tag, w_valid, w_cnt
    );

    modport slave (
        input  alloc_req, alloc_tag, upd_valid, upd_idx, upd_taken, cnt_rd_data,
        output alloc_ready, upd_ready, cnt_rd_idx,
        output w_en, w_idx, w_tag_en, w_tag, w_valid, w_cnt
    );

endinterface

// File: rtl/bpb_write_scheduler_upd_fifo.sv
// In-order queue of resolved-branch updates. Entries carry a live bit that a
// reallocation of the same BPB index can clear while the entry waits.
module bpb_upd_fifo
    import bpb_pkg::*;
#(
    parameter int IDX_W  = 4,
    parameter int QDEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [IDX_W-1:0] push_idx_i,
    input  logic             push_taken_i,
    input  logic             push_live_i,
    input  logic             pop_i,
    input  logic             kill_en_i,
    input  logic [IDX_W-1:0] kill_idx_i,
    output logic [IDX_W-1:0] head_idx_o,
    output logic             head_taken_o,
    output logic             head_live_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = $clog2(QDEPTH + 1);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
        logic             live;
    } upd_entry_t;

    upd_entry_t       mem_q [QDEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Occupancy next-state; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and live-bit kill; the pushed slot is written last so a
    // fresh entry keeps the live value decided for it this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (kill_en_i && (mem_q[i].idx == kill_idx_i)) begin
                    mem_q[i].live <= 1'b0;
                end
            end
            if (push_i) begin
                mem_q[tail_q] <= '{idx: push_idx_i, taken: push_taken_i, live: push_live_i};
                tail_q        <= tail_q + PTR_W'(1);
            end
            if (pop_i) begin
                head_q <= head_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    assign head_idx_o   = mem_q[head_q].idx;
    assign head_taken_o = mem_q[head_q].taken;
    assign head_live_o  = mem_q[head_q].live;
    assign empty_o      = (count_q == CNT_W'(0));
    assign full_o       = (count_q == CNT_W'(QDEPTH));

endmodule

// File: rtl/bpb_write_scheduler.sv
// Single BPB write port shared by fetch-side allocation and execute-side
// counter updates. Allocation wins unless the update queue is full.
module bpb_write_scheduler
    import bpb_pkg::*;
#(
    parameter int ENTRIES   = 16,
    parameter int TAG_WIDTH = 30,
    parameter int QDEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    flush,
    bpb_write_scheduler_if.slave    bus
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [IDX_W-1:0]     vptr_q;
    logic [IDX_W-1:0]     vptr_d;
    logic                 alloc_eff_s;
    logic                 grant_upd_s;
    logic                 grant_alloc_s;
    logic                 upd_ready_s;
    logic                 push_s;
    logic                 push_live_s;
    logic [IDX_W-1:0]     head_idx_s;
    logic                 head_taken_s;
    logic                 head_live_s;
    logic                 fifo_empty_s;
    logic                 fifo_full_s;
    logic                 w_en_s;
    logic                 w_tag_en_s;
    logic [IDX_W-1:0]     w_idx_s;
    logic [TAG_WIDTH-1:0] w_tag_s;
    cnt_t                 w_cnt_s;

    // Arbitration: a flushed request counts as absent, and a full queue drains first.
    always_comb begin
        alloc_eff_s   = bus.alloc_req & ~flush;
        grant_upd_s   = ~reset & ~stall & ~fifo_empty_s & (~alloc_eff_s | fifo_full_s);
        grant_alloc_s = ~reset & ~stall & alloc_eff_s & ~grant_upd_s;
        upd_ready_s   = ~fifo_full_s | grant_upd_s;
        push_s        = bus.upd_valid & upd_ready_s;
        push_live_s   = ~(grant_alloc_s & (bus.upd_idx == vptr_q));
        if (grant_alloc_s) begin
            vptr_d = vptr_q + IDX_W'(1);
        end else begin
            vptr_d = vptr_q;
        end
    end

    // Write-port mux; a dead head is popped without touching the array.
    always_comb begin
        w_en_s     = 1'b0;
        w_tag_en_s = 1'b0;
        w_idx_s    = vptr_q;
        w_tag_s    = bus.alloc_tag;
        w_cnt_s    = CNT_WEAK_NT;
        if (grant_alloc_s) begin
            w_en_s     = 1'b1;
            w_tag_en_s = 1'b1;
        end else if (grant_upd_s && head_live_s) begin
            w_en_s  = 1'b1;
            w_idx_s = head_idx_s;
            w_cnt_s = cnt_sat_update(bus.cnt_rd_data, head_taken_s);
        end else begin
            w_en_s = 1'b0;
        end
    end

    // Round-robin victim pointer; holds under stall because no grant is given.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vptr_q <= '0;
        end else begin
            vptr_q <= vptr_d;
        end
    end

    bpb_upd_fifo #(
        .IDX_W  (IDX_W),
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push_s),
        .push_idx_i   (bus.upd_idx),
        .push_taken_i (bus.upd_taken),
        .push_live_i  (push_live_s),
        .pop_i        (grant_upd_s),
        .kill_en_i    (grant_alloc_s),
        .kill_idx_i   (vptr_q),
        .head_idx_o   (head_idx_s),
        .head_taken_o (head_taken_s),
        .head_live_o  (head_live_s),
        .empty_o      (fifo_empty_s),
        .full_o       (fifo_full_s)
    );

    assign bus.alloc_ready = grant_alloc_s;
    assign bus.upd_ready   = upd_ready_s;
    assign bus.cnt_rd_idx  = head_idx_s;
    assign bus.w_en        = w_en_s;
    assign bus.w_idx       = w_idx_s;
    assign bus.w_tag_en    = w_tag_en_s;
    assign bus.w_tag       = w_tag_s;
    assign bus.w_valid     = 1'b1;
    assign bus.w_cnt       = w_cnt_s;

endmodule
